dht11_sampler: RTL and testbench

//  Measurement sequencer between the debounced start button, dht11_controller and fnd_controller.

---
 rtl/dht11_sampler.sv | 241 ++++++++++++++++++++++++
 tb/tb_dht11_sampler.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dht11_sampler.sv
// DHT11 measurement sequencer: manual/auto triggering with timeout and retry,
// then a moving average, min/max, FND word select and a hysteresis temperature alarm.
module dht11_sampler #(
  parameter int         CLK_HZ     = 100_000_000,
  parameter int         PERIOD_MS  = 2000,
  parameter int         TIMEOUT_MS = 30,
  parameter int         RETRY_MS   = 1000,
  parameter int         MAX_RETRY  = 2,
  parameter int         AVG_LOG2   = 2,
  parameter logic [7:0] ALARM_HI   = 8'd30,
  parameter logic [7:0] ALARM_LO   = 8'd28
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_manual,
  input  logic        i_auto_en,
  input  logic [1:0]  i_mode,
  output logic        o_dht_start,
  input  logic        i_dht_done,
  input  logic        i_dht_valid,
  input  logic [15:0] i_humidity,
  input  logic [15:0] i_temperature,
  output logic [15:0] o_fnd_data,
  output logic        o_sample_valid,
  output logic        o_error,
  output logic        o_alarm,
  output logic [2:0]  o_state
);
  localparam int TICK_DIV = (CLK_HZ >= 2000) ? CLK_HZ / 1000 : 1;
  localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IDLE_TOP = (PERIOD_MS > RETRY_MS) ? PERIOD_MS : RETRY_MS;
  localparam int CNT_TOP  = (IDLE_TOP > TIMEOUT_MS) ? IDLE_TOP : TIMEOUT_MS;
  localparam int CNT_W    = $clog2(CNT_TOP + 1);
  localparam int D        = 1 << AVG_LOG2;
  localparam int PTR_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int SUM_W    = 8 + AVG_LOG2;
  localparam int RC_W     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_TRIG  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_ACCUM = 3'd3;
  localparam logic [2:0] S_FAIL  = 3'd4;

  logic [PRE_W-1:0]     pre_q;
  logic                 tick, accum;
  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     ms_q, ms_d;
  logic [RC_W-1:0]      rc_q, rc_d;
  logic                 pend_q, pend_d, err_q, err_d;
  logic [7:0]           hin_q, hin_d, tin_q, tin_d;
  logic [D-1:0][7:0]    hbuf_q, tbuf_q;
  logic [PTR_W-1:0]     wp_q, wp_d;
  logic [SUM_W-1:0]     hsum_q, hsum_d, tsum_q, tsum_d;
  logic [7:0]           hmin_q, hmin_d, hmax_q, hmax_d, tmin_q, tmin_d, tmax_q, tmax_d;
  logic                 have_q, have_d;
  logic [15:0]          fnd_q, fnd_d;
  logic                 eval_q, alarm_q;
  logic [7:0]           havg_d, tavg_d, tavg_cur;
  logic                 unused_dec;

  assign unused_dec = ^{i_humidity[7:0], i_temperature[7:0]};

  assign tick  = (pre_q == PRE_W'(TICK_DIV - 1));
  assign accum = (state_q == S_ACCUM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pre_q <= '0;
    else      pre_q <= tick ? '0 : pre_q + 1'b1;
  end

  // Idle counter wraps at the longer of the two holdoffs so either compare is always reachable.
  always_comb begin
    state_d = state_q;
    ms_d    = ms_q;
    rc_d    = rc_q;
    pend_d  = pend_q;
    err_d   = err_q;
    hin_d   = hin_q;
    tin_d   = tin_q;
    case (state_q)
      S_IDLE: begin
        if (tick) ms_d = (ms_q == CNT_W'(IDLE_TOP - 1)) ? '0 : ms_q + 1'b1;
        if (i_manual ||
            (tick && ((i_auto_en && ms_q == CNT_W'(PERIOD_MS - 1)) ||
                      (pend_q    && ms_q == CNT_W'(RETRY_MS - 1)))))
          state_d = S_TRIG;
      end
      S_TRIG: begin
        ms_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_dht_done) begin
          if (i_dht_valid) begin
            hin_d   = i_humidity[15:8];
            tin_d   = i_temperature[15:8];
            state_d = S_ACCUM;
          end else begin
            state_d = S_FAIL;
          end
        end else if (tick) begin
          ms_d = ms_q + 1'b1;
          if (ms_q == CNT_W'(TIMEOUT_MS - 1)) state_d = S_FAIL;
        end
      end
      S_ACCUM: begin
        rc_d    = '0;
        pend_d  = 1'b0;
        err_d   = 1'b0;
        ms_d    = '0;
        state_d = S_IDLE;
      end
      S_FAIL: begin
        ms_d = '0;
        if (rc_q < RC_W'(MAX_RETRY)) begin
          rc_d   = rc_q + 1'b1;
          pend_d = 1'b1;
        end else begin
          err_d  = 1'b1;
          rc_d   = '0;
          pend_d = 1'b0;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // First sample primes every slot so the average is meaningful immediately.
  always_comb begin
    wp_d   = wp_q;
    hsum_d = hsum_q;
    tsum_d = tsum_q;
    hmin_d = hmin_q;
    hmax_d = hmax_q;
    tmin_d = tmin_q;
    tmax_d = tmax_q;
    have_d = have_q;
    if (accum) begin
      have_d = 1'b1;
      if (!have_q) begin
        hsum_d = SUM_W'(hin_q) << AVG_LOG2;
        tsum_d = SUM_W'(tin_q) << AVG_LOG2;
        hmin_d = hin_q;
        hmax_d = hin_q;
        tmin_d = tin_q;
        tmax_d = tin_q;
        wp_d   = '0;
      end else begin
        hsum_d = hsum_q - SUM_W'(hbuf_q[wp_q]) + SUM_W'(hin_q);
        tsum_d = tsum_q - SUM_W'(tbuf_q[wp_q]) + SUM_W'(tin_q);
        if (hin_q < hmin_q) hmin_d = hin_q;
        if (hin_q > hmax_q) hmax_d = hin_q;
        if (tin_q < tmin_q) tmin_d = tin_q;
        if (tin_q > tmax_q) tmax_d = tin_q;
        wp_d = (wp_q == PTR_W'(D - 1)) ? '0 : wp_q + 1'b1;
      end
    end
  end

  assign havg_d   = hsum_d[SUM_W-1:AVG_LOG2];
  assign tavg_d   = tsum_d[SUM_W-1:AVG_LOG2];
  assign tavg_cur = tsum_q[SUM_W-1:AVG_LOG2];

  // Selecting from next-state stats makes the word track both ACCUM and mode changes.
  always_comb begin
    fnd_d = 16'h0000;
    if (have_d) begin
      case (i_mode)
        2'b00:   fnd_d = {hin_q, tin_q};
        2'b01:   fnd_d = {havg_d, tavg_d};
        2'b10:   fnd_d = {tmax_d, tmin_d};
        default: fnd_d = {hmax_d, hmin_d};
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ms_q    <= '0;
      rc_q    <= '0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      hin_q   <= '0;
      tin_q   <= '0;
      hbuf_q  <= '0;
      tbuf_q  <= '0;
      wp_q    <= '0;
      hsum_q  <= '0;
      tsum_q  <= '0;
      hmin_q  <= '0;
      hmax_q  <= '0;
      tmin_q  <= '0;
      tmax_q  <= '0;
      have_q  <= 1'b0;
      fnd_q   <= '0;
      eval_q  <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ms_q    <= ms_d;
      rc_q    <= rc_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      hin_q   <= hin_d;
      tin_q   <= tin_d;
      if (accum) begin
        if (!have_q) begin
          hbuf_q <= {D{hin_q}};
          tbuf_q <= {D{tin_q}};
        end else begin
          hbuf_q[wp_q] <= hin_q;
          tbuf_q[wp_q] <= tin_q;
        end
      end
      wp_q    <= wp_d;
      hsum_q  <= hsum_d;
      tsum_q  <= tsum_d;
      hmin_q  <= hmin_d;
      hmax_q  <= hmax_d;
      tmin_q  <= tmin_d;
      tmax_q  <= tmax_d;
      have_q  <= have_d;
      fnd_q   <= fnd_d;
      eval_q  <= accum;
      if (eval_q) begin
        if (tavg_cur >= ALARM_HI)      alarm_q <= 1'b1;
        else if (tavg_cur <= ALARM_LO) alarm_q <= 1'b0;
      end
    end
  end

  assign o_dht_start    = (state_q == S_TRIG);
  assign o_sample_valid = accum;
  assign o_error        = err_q;
  assign o_alarm        = alarm_q;
  assign o_state        = state_q;
  assign o_fnd_data     = fnd_q;
endmodule

// File: tb/tb_dht11_sampler.sv
// Directed + randomized bench for dht11_sampler against a sample-history model
// (last-four window average, running min/max, hysteresis alarm, timing in ms ticks).
module tb_dht11_sampler;
  localparam int PERIOD_MS  = 10;
  localparam int TIMEOUT_MS = 5;
  localparam int RETRY_MS   = 3;
  localparam int MAX_RETRY  = 2;

  logic        clk = 1'b0, rst = 1'b0;
  logic        i_manual = 1'b0, i_auto_en = 1'b0;
  logic [1:0]  i_mode = 2'b00;
  logic        i_dht_done = 1'b0, i_dht_valid = 1'b0;
  logic [15:0] i_humidity = '0, i_temperature = '0;
  logic        o_dht_start, o_sample_valid, o_error, o_alarm;
  logic [15:0] o_fnd_data;
  logic [2:0]  o_state;

  int          nchk = 0, nerr = 0;
  int          hq[$], tq[$];
  logic        alarm_m = 1'b0;
  logic [7:0]  rh, rt;
  int          rl, n;
  int          t2_t[3]   = '{27, 29, 31};
  int          t2_avg[3] = '{25, 26, 28};
  int          t6_t[4]   = '{29, 33, 25, 25};
  logic        t6_al[4]  = '{1'b0, 1'b1, 1'b1, 1'b0};

  dht11_sampler #(
    .CLK_HZ(1000), .PERIOD_MS(PERIOD_MS), .TIMEOUT_MS(TIMEOUT_MS), .RETRY_MS(RETRY_MS),
    .MAX_RETRY(MAX_RETRY), .AVG_LOG2(2), .ALARM_HI(8'd30), .ALARM_LO(8'd28)
  ) dut (
    .clk(clk), .rst(rst), .i_manual(i_manual), .i_auto_en(i_auto_en), .i_mode(i_mode),
    .o_dht_start(o_dht_start), .i_dht_done(i_dht_done), .i_dht_valid(i_dht_valid),
    .i_humidity(i_humidity), .i_temperature(i_temperature), .o_fnd_data(o_fnd_data),
    .o_sample_valid(o_sample_valid), .o_error(o_error), .o_alarm(o_alarm), .o_state(o_state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Average over the last four accepted samples; the first sample fills missing history.
  function automatic logic [7:0] avg4(input bit temp);
    int s, sz, idx;
    s  = 0;
    sz = temp ? tq.size() : hq.size();
    for (int k = 0; k < 4; k++) begin
      idx = sz - 1 - k;
      if (idx < 0) idx = 0;
      s += temp ? tq[idx] : hq[idx];
    end
    return 8'(s / 4);
  endfunction

  function automatic logic [7:0] ext(input bit temp, input bit want_max);
    int r;
    r = temp ? tq[0] : hq[0];
    for (int k = 0; k < tq.size(); k++) begin
      int v;
      v = temp ? tq[k] : hq[k];
      if (want_max ? (v > r) : (v < r)) r = v;
    end
    return 8'(r);
  endfunction

  function automatic logic [15:0] fnd_model(input logic [1:0] m);
    if (tq.size() == 0) return 16'h0000;
    case (m)
      2'b00:   return {8'(hq[hq.size()-1]), 8'(tq[tq.size()-1])};
      2'b01:   return {avg4(1'b0), avg4(1'b1)};
      2'b10:   return {ext(1'b1, 1'b1), ext(1'b1, 1'b0)};
      default: return {ext(1'b0, 1'b1), ext(1'b0, 1'b0)};
    endcase
  endfunction

  task automatic accept(input logic [7:0] h, input logic [7:0] t);
    logic [7:0] a;
    hq.push_back(int'(h));
    tq.push_back(int'(t));
    a = avg4(1'b1);
    if (a >= 8'd30)      alarm_m = 1'b1;
    else if (a <= 8'd28) alarm_m = 1'b0;
  endtask

  // Called on the negedge where the trigger pulse is visible; leaves two cycles into IDLE.
  task automatic respond(input bit valid, input logic [7:0] h, input logic [7:0] t,
                         input int lat, input bit man);
    repeat (lat) @(negedge clk);
    i_dht_done    = 1'b1;
    i_dht_valid   = valid;
    i_humidity    = {h, 8'($urandom_range(0, 99))};
    i_temperature = {t, 8'($urandom_range(0, 99))};
    i_manual      = man;
    @(negedge clk);
    i_dht_done  = 1'b0;
    i_dht_valid = 1'b0;
    i_manual    = 1'b0;
    if (valid) begin
      chk("sample_valid", o_sample_valid, 1);
      chk("state_accum", o_state, 3);
      accept(h, t);
    end else begin
      chk("state_fail", o_state, 4);
    end
    @(negedge clk);
    chk("sample_valid_low", o_sample_valid, 0);
    chk("fnd", o_fnd_data, fnd_model(i_mode));
    @(negedge clk);
    chk("alarm", o_alarm, alarm_m);
  endtask

  task automatic manual_read(input bit valid, input logic [7:0] h, input logic [7:0] t, input int lat);
    @(negedge clk) i_manual = 1'b1;
    @(negedge clk) i_manual = 1'b0;
    chk("start_pulse", o_dht_start, 1);
    chk("state_trig", o_state, 1);
    respond(valid, h, t, lat, 1'b0);
  endtask

  task automatic wait_start(input int max, input int exp_n, input string tag);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!o_dht_start && k < max);
    chk(tag, k, exp_n);
  endtask

  task automatic no_start(input int cycles, input string tag);
    int c;
    c = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (o_dht_start) c++;
    end
    chk(tag, c, 0);
  endtask

  task automatic check_modes();
    for (int m = 0; m < 4; m++) begin
      @(negedge clk) i_mode = 2'(m);
      @(negedge clk);
      chk("mode_select", o_fnd_data, fnd_model(2'(m)));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_start", o_dht_start, 0);
    chk("rst_svalid", o_sample_valid, 0);
    chk("rst_error", o_error, 0);
    chk("rst_alarm", o_alarm, 0);
    chk("rst_state", o_state, 0);
    chk("rst_fnd", o_fnd_data, 0);
    rst = 1'b1;
    i_mode = 2'b01;
    repeat (2) @(negedge clk);
    chk("fnd_no_data", o_fnd_data, 0);
    i_mode = 2'b00;

    // first sample
    manual_read(1'b1, 8'h37, 8'h19, 3);
    chk("t1_mode00", o_fnd_data, 16'h3719);
    i_mode = 2'b01;
    repeat (2) @(negedge clk);
    chk("t1_mode01", o_fnd_data, 16'h3719);

    // moving average
    for (int k = 0; k < 3; k++) begin
      manual_read(1'b1, 8'h37, 8'(t2_t[k]), 2);
      chk("t2_avg", o_fnd_data[7:0], t2_avg[k]);
    end
    i_mode = 2'b10;
    repeat (2) @(negedge clk);
    chk("t2_mode10", o_fnd_data, 16'h1F19);
    check_modes();

    // timeout, retries, sticky error
    @(negedge clk) i_manual = 1'b1;
    @(negedge clk) i_manual = 1'b0;
    chk("t4_trig", o_dht_start, 1);
    for (int r = 0; r < MAX_RETRY; r++) begin
      wait_start(40, 1 + TIMEOUT_MS + 1 + RETRY_MS, "t4_retry_gap");
      chk("t4_err_low", o_error, 0);
    end
    repeat (1 + TIMEOUT_MS + 1) @(negedge clk);
    chk("t4_err_set", o_error, 1);
    chk("t4_idle", o_state, 0);
    no_start(40, "t4_no_more_retry");
    manual_read(1'b1, 8'd40, 8'd24, 4);
    chk("t4_err_clear", o_error, 0);

    // invalid checksum then good retry
    manual_read(1'b0, 8'd41, 8'd26, 2);
    chk("t5_err_low", o_error, 0);
    wait_start(20, RETRY_MS - 1, "t5_retry_gap");
    respond(1'b1, 8'd42, 8'd27, 3, 1'b0);
    chk("t5_err_still_low", o_error, 0);

    // done and timeout in the same cycle: done is accepted
    manual_read(1'b1, 8'd43, 8'd28, TIMEOUT_MS);

    // randomized reads
    for (int k = 0; k < 16; k++) begin
      i_mode = 2'($urandom_range(0, 3));
      rh = 8'($urandom_range(10, 90));
      rt = 8'($urandom_range(20, 40));
      rl = $urandom_range(1, TIMEOUT_MS);
      if ($urandom_range(0, 3) == 0) begin
        manual_read(1'b0, rh, rt, rl);
        wait_start(20, RETRY_MS - 1, "rnd_retry_gap");
        respond(1'b1, rh, rt, $urandom_range(1, TIMEOUT_MS), 1'b0);
      end else begin
        manual_read(1'b1, rh, rt, rl);
      end
    end
    check_modes();

    // periodic triggering; a manual press during WAIT must not add a trigger
    i_auto_en = 1'b1;
    n = 0;
    while (!o_dht_start && n < PERIOD_MS + 5) begin
      @(negedge clk);
      n++;
    end
    chk("auto_first", o_dht_start, 1);
    for (int k = 0; k < 6; k++) begin
      respond(1'b1, 8'($urandom_range(10, 90)), 8'($urandom_range(20, 40)),
              $urandom_range(1, TIMEOUT_MS), k == 2);
      wait_start(PERIOD_MS + 5, PERIOD_MS - 1, "auto_gap");
    end
    i_auto_en = 1'b0;
    respond(1'b1, 8'd50, 8'd30, 2, 1'b0);
    no_start(30, "auto_off_no_start");

    // reset in WAIT abandons the read
    @(negedge clk) i_manual = 1'b1;
    @(negedge clk) i_manual = 1'b0;
    @(negedge clk);
    chk("rst_mid_wait_state", o_state, 2);
    rst = 1'b0;
    #1;
    chk("rstw_start", o_dht_start, 0);
    chk("rstw_svalid", o_sample_valid, 0);
    chk("rstw_error", o_error, 0);
    chk("rstw_alarm", o_alarm, 0);
    chk("rstw_state", o_state, 0);
    chk("rstw_fnd", o_fnd_data, 0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    i_dht_done = 1'b1;
    i_dht_valid = 1'b1;
    i_temperature = 16'h2000;
    @(negedge clk);
    i_dht_done = 1'b0;
    i_dht_valid = 1'b0;
    chk("late_done_ignored", o_sample_valid, 0);
    chk("late_done_idle", o_state, 0);
    @(negedge clk);
    chk("late_done_fnd", o_fnd_data, 0);
    hq.delete();
    tq.delete();
    alarm_m = 1'b0;

    // alarm hysteresis: averages 29, 30, 29, 28
    i_mode = 2'b01;
    for (int k = 0; k < 4; k++) begin
      manual_read(1'b1, 8'd50, 8'(t6_t[k]), 2);
      chk("t6_alarm_seq", o_alarm, t6_al[k]);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
